// File: rtl/loop_mem_ctrl.sv
// loop_mem_ctrl: sequences the looper sample RAM for record and cyclic playback.
// Records one sample per sample_tick and keeps the loop length. Plays the loop back
// cyclically, one sample per tick, and pulses loop_wrap when playback returns to address 0.
// Optional build macro OVERDUB_EN: during playback with overdub=1, the returning sample is
// summed with the microphone sample (saturating) and written back to the same address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no RAM traffic; loop_len and mem_addr hold
// ST_REC  | write mic_sample per tick until the buffer is full
// ST_PLAY | read one loop sample per tick, wrapping at loop_len
module loop_mem_ctrl #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rec_en,
   input  logic              play_en,
   input  logic              sample_tick,
   input  logic [DATA_W-1:0] mic_sample,
   input  logic              overdub,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] play_sample,
   output logic              play_valid,
   output logic [ADDR_W:0]   loop_len,
   output logic              rec_full,
   output logic              loop_wrap
);

   typedef enum logic [1:0] {ST_IDLE, ST_REC, ST_PLAY} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, addr_q;
   logic [ADDR_W:0]   len_q;
   logic              rd_pend_q, wrap_pend_q;
   logic [DATA_W-1:0] play_q;
   logic              tick, rec_wr, play_rd, rd_ret, rd_last;

   // Ticks arriving while reset is held are dropped, and a read returning
   // during reset never reaches the outputs.
   assign tick     = sample_tick & ~rst;
   assign rec_full = len_q[ADDR_W];
   assign loop_len = len_q;
   assign rec_wr   = (state_q == ST_REC) & tick & ~rec_full;
   assign play_rd  = (state_q == ST_PLAY) & tick & (len_q != '0);
   assign rd_ret   = rd_pend_q & (state_q == ST_PLAY) & ~rst;
   assign rd_last  = ({1'b0, rd_ptr_q} == (len_q - 1'b1));

`ifdef OVERDUB_EN
   logic [DATA_W-1:0] mic_q;
   logic [DATA_W:0]   od_sum;
   assign od_sum = {1'b0, mem_rdata} + {1'b0, mic_q};
`else
   logic unused_overdub;
   assign unused_overdub = overdub;
`endif

   // State register and the sequencing counters/pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         rd_pend_q   <= 1'b0;
         wrap_pend_q <= 1'b0;
         play_q      <= '0;
`ifdef OVERDUB_EN
         mic_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rd_pend_q   <= play_rd;
         wrap_pend_q <= play_rd & rd_last;
         if (rec_wr)
            addr_q <= wr_ptr_q;
         else if (play_rd)
            addr_q <= rd_ptr_q;
         if (state_q != ST_PLAY)
            play_q <= '0;
         else if (rd_ret)
            play_q <= mem_rdata;
         // a new take always starts from an empty buffer
         if (state_d == ST_REC && state_q != ST_REC) begin
            wr_ptr_q <= '0;
            len_q    <= '0;
         end else if (rec_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            len_q    <= len_q + 1'b1;
         end
         if (state_d == ST_PLAY && state_q != ST_PLAY)
            rd_ptr_q <= '0;
         else if (play_rd)
            rd_ptr_q <= rd_last ? '0 : rd_ptr_q + 1'b1;
`ifdef OVERDUB_EN
         if (play_rd)
            mic_q <= mic_sample;
`endif
      end
   end

   // Next-state mode select (record wins) and RAM/playback outputs
   always_comb begin
      state_d     = ST_IDLE;
      mem_addr    = addr_q;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      play_valid  = rd_ret;
      loop_wrap   = rd_ret & wrap_pend_q;
      play_sample = '0;
      if (rec_en)
         state_d = ST_REC;
      else if (play_en)
         state_d = ST_PLAY;
      if (state_q == ST_PLAY)
         play_sample = rd_ret ? mem_rdata : play_q;
      if (rec_wr) begin
         mem_addr  = wr_ptr_q;
         mem_we    = 1'b1;
         mem_wdata = mic_sample;
      end else if (play_rd) begin
         mem_addr = rd_ptr_q;
      end
`ifdef OVERDUB_EN
      else if (rd_ret && overdub) begin
         mem_we    = 1'b1;
         mem_wdata = od_sum[DATA_W] ? '1 : od_sum[DATA_W-1:0];
      end
`endif
   end

endmodule

// File: tb/tb_loop_mem_ctrl.sv
// Testbench for loop_mem_ctrl (ADDR_W=4): bench-side RAM, a behavioural model checked
// every cycle, and literal expectations for the directed scenarios.
module tb_loop_mem_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int MAXV = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rec_en = 1'b0, play_en = 1'b0, sample_tick = 1'b0, overdub = 1'b0;
   logic [DW-1:0] mic_sample = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] play_sample;
   logic          play_valid;
   logic [AW:0]   loop_len;
   logic          rec_full, loop_wrap;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] ram [DEPTH];

   int wr_addr_log[$];
   int wr_data_log[$];
   int play_log[$];
   int wrap_log[$];

   loop_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .rec_en(rec_en), .play_en(play_en),
      .sample_tick(sample_tick), .mic_sample(mic_sample), .overdub(overdub),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .play_sample(play_sample), .play_valid(play_valid), .loop_len(loop_len),
      .rec_full(rec_full), .loop_wrap(loop_wrap)
   );

   always #5 clk = ~clk;

   // single-port RAM with one-cycle read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // event logs for the literal checks
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         wr_addr_log.push_back(int'(mem_addr));
         wr_data_log.push_back(int'(mem_wdata));
      end
      if (!rst && play_valid) begin
         play_log.push_back(int'(play_sample));
         wrap_log.push_back(int'(loop_wrap));
      end
   end

   // behavioural model: mode 0 idle, 1 record, 2 play
   int m_mode = 0, m_len = 0, m_wr = 0, m_rd = 0, m_addr = 0;
   int m_pend_addr = 0, m_mic = 0, m_psamp = 0;
   bit m_pend = 0, m_pwrap = 0;
   int m_store[DEPTH];

   always @(negedge clk) begin
      int e_addr, e_wd, e_ps, nmode;
      bit e_we, e_pv, e_wrap, rec_w, play_r;
      if (rst) begin
         check("rst_play_valid", int'(play_valid), 0);
         check("rst_mem_we", int'(mem_we), 0);
         m_mode = 0; m_len = 0; m_wr = 0; m_rd = 0; m_addr = 0;
         m_pend = 0; m_pwrap = 0; m_psamp = 0; m_mic = 0;
      end else begin
         rec_w  = (m_mode == 1) && sample_tick && (m_len < DEPTH);
         play_r = (m_mode == 2) && sample_tick && (m_len > 0);
         e_pv   = m_pend && (m_mode == 2);
         e_wrap = e_pv && m_pwrap;
         e_ps   = (m_mode != 2) ? 0 : (e_pv ? m_store[m_pend_addr] : m_psamp);
         e_we   = 0; e_addr = m_addr; e_wd = 0;
         if (rec_w) begin
            e_we = 1; e_addr = m_wr; e_wd = int'(mic_sample);
         end else if (play_r) begin
            e_addr = m_rd;
         end
`ifdef OVERDUB_EN
         else if (e_pv && overdub) begin
            e_we = 1; e_addr = m_pend_addr;
            e_wd = (m_store[m_pend_addr] + m_mic > MAXV) ? MAXV : m_store[m_pend_addr] + m_mic;
         end
`endif
         check("mem_addr", int'(mem_addr), e_addr);
         check("mem_we", int'(mem_we), int'(e_we));
         if (e_we) check("mem_wdata", int'(mem_wdata), e_wd);
         check("play_valid", int'(play_valid), int'(e_pv));
         check("play_sample", int'(play_sample), e_ps);
         check("loop_wrap", int'(loop_wrap), int'(e_wrap));
         check("loop_len", int'(loop_len), m_len);
         check("rec_full", int'(rec_full), int'(m_len == DEPTH));
         // advance the model to the state after the coming clock edge
         if (e_pv) m_psamp = e_ps;
         if (e_we && m_mode == 2) m_store[m_pend_addr] = e_wd;
         if (rec_w) begin
            m_store[m_wr] = int'(mic_sample);
            m_wr++; m_len++; m_addr = e_addr;
         end
         if (play_r) begin
            m_pend = 1; m_pend_addr = m_rd; m_pwrap = (m_rd == m_len - 1);
            m_rd = m_pwrap ? 0 : m_rd + 1;
            m_addr = e_addr; m_mic = int'(mic_sample);
         end else begin
            m_pend = 0;
         end
         if (m_mode != 2) m_psamp = 0;
         nmode = rec_en ? 1 : (play_en ? 2 : 0);
         if (nmode == 1 && m_mode != 1) begin m_wr = 0; m_len = 0; end
         if (nmode == 2 && m_mode != 2) m_rd = 0;
         m_mode = nmode;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input int s);
      sample_tick = 1'b1; mic_sample = DW'(s);
      cyc(1);
      sample_tick = 1'b0;
      cyc(3);
   endtask

   task automatic clear_logs();
      wr_addr_log.delete(); wr_data_log.delete(); play_log.delete(); wrap_log.delete();
   endtask

   initial begin
      int rec_a[5];
      int play_e[7];
      rec_a  = '{10, 20, 30, 40, 50};
      play_e = '{10, 20, 30, 40, 50, 10, 20};
      for (int i = 0; i < DEPTH; i++) ram[i] = '0;

      // reset with a stray tick and rec_en that must be ignored
      rst = 1'b1; rec_en = 1'b1;
      cyc(1);
      sample_tick = 1'b1; mic_sample = 8'd99;
      cyc(1);
      sample_tick = 1'b0; rec_en = 1'b0;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      check("reset_loop_len", int'(loop_len), 0);
      check("reset_mem_addr", int'(mem_addr), 0);
      check("reset_play_sample", int'(play_sample), 0);
      check("reset_rec_full", int'(rec_full), 0);
      cyc(1);

      // record five samples
      clear_logs();
      rec_en = 1'b1; cyc(1);
      foreach (rec_a[i]) do_tick(rec_a[i]);
      check("rec5_writes", wr_addr_log.size(), 5);
      for (int i = 0; i < 5 && i < wr_addr_log.size(); i++) begin
         check("rec5_addr", wr_addr_log[i], i);
         check("rec5_data", wr_data_log[i], rec_a[i]);
      end
      check("rec5_loop_len", int'(loop_len), 5);
      check("rec5_rec_full", int'(rec_full), 0);

      // play seven ticks; overdub request must not disturb the default build
      clear_logs();
      rec_en = 1'b0; play_en = 1'b1; cyc(1);
      foreach (play_e[i]) do_tick(i * 3);
      check("play7_count", play_log.size(), 7);
      for (int i = 0; i < 7 && i < play_log.size(); i++) begin
         check("play7_sample", play_log[i], play_e[i]);
         check("play7_wrap", wrap_log[i], (i == 4) ? 1 : 0);
      end
      check("play7_writes", wr_addr_log.size(), 0);
`ifndef OVERDUB_EN
      clear_logs();
      overdub = 1'b1;
      do_tick(77); do_tick(78);
      overdub = 1'b0;
      check("overdub_ignored_writes", wr_addr_log.size(), 0);
      check("overdub_ignored_play", play_log.size(), 2);
`endif

      // overflow: 18 ticks into a 16-deep buffer
      clear_logs();
      play_en = 1'b0; rec_en = 1'b1; cyc(1);
      for (int i = 1; i <= 18; i++) do_tick(i);
      check("full_writes", wr_addr_log.size(), 16);
      for (int i = 0; i < wr_addr_log.size(); i++) check("full_addr", wr_addr_log[i], i);
      check("full_loop_len", int'(loop_len), 16);
      check("full_rec_full", int'(rec_full), 1);

      // record priority over play
      rec_en = 1'b0; cyc(2);
      clear_logs();
      rec_en = 1'b1; play_en = 1'b1; cyc(1);
      @(negedge clk);
      check("prio_cleared_len", int'(loop_len), 0);
      cyc(1);
      do_tick(5); do_tick(6);
      check("prio_writes", wr_addr_log.size(), 2);
      check("prio_loop_len", int'(loop_len), 2);

      // empty loop: re-enter record without ticks, then play
      rec_en = 1'b0; cyc(2);
      rec_en = 1'b1; cyc(2);
      clear_logs();
      rec_en = 1'b0; cyc(1);
      for (int i = 0; i < 4; i++) do_tick(i);
      check("empty_play_valid", play_log.size(), 0);
      check("empty_writes", wr_addr_log.size(), 0);

      // reset while a read is returning
      play_en = 1'b0; rec_en = 1'b1; cyc(1);
      do_tick(7); do_tick(8); do_tick(9);
      rec_en = 1'b0; play_en = 1'b1; cyc(1);
      clear_logs();
      sample_tick = 1'b1; cyc(1);
      sample_tick = 1'b0; rst = 1'b1; play_en = 1'b0;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_play_log", play_log.size(), 0);
      check("rstmid_loop_len", int'(loop_len), 0);
      check("rstmid_play_sample", int'(play_sample), 0);
      check("rstmid_play_valid", int'(play_valid), 0);
      check("rstmid_mem_addr", int'(mem_addr), 0);
      check("rstmid_mem_we", int'(mem_we), 0);
      check("rstmid_loop_wrap", int'(loop_wrap), 0);
      cyc(1);

`ifdef OVERDUB_EN
      // saturating overdub: 200 + 100 -> 255 written back to address 0
      rec_en = 1'b1; cyc(1);
      do_tick(200);
      rec_en = 1'b0; play_en = 1'b1; overdub = 1'b1; cyc(1);
      clear_logs();
      do_tick(100);
      overdub = 1'b0;
      check("od_play_count", play_log.size(), 1);
      if (play_log.size() > 0) check("od_play_sample", play_log[0], 200);
      check("od_writes", wr_addr_log.size(), 1);
      if (wr_addr_log.size() > 0) begin
         check("od_addr", wr_addr_log[0], 0);
         check("od_data", wr_data_log[0], 255);
      end
      play_en = 1'b0; cyc(2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
